// File: rtl/timer_slave_pkg.sv
// -----------------------------------------------------------------------------
// timer_slave_pkg
// Shared definitions for the memory-mapped timer responder:
//   - register word offsets decoded from addr_i[3:0]
//   - CTRL register bit positions
//   - helper that packs the CTRL fields into a 32-bit read word
// -----------------------------------------------------------------------------
package timer_slave_pkg;

  // Register offsets (addr_i[3:0])
  localparam logic [3:0] TIMER_CTRL     = 4'h0;
  localparam logic [3:0] TIMER_COUNT    = 4'h4;
  localparam logic [3:0] TIMER_VALUE    = 4'h8;
  localparam logic [3:0] TIMER_PRESCALE = 4'hC;

  // CTRL bit indices
  localparam int TIMER_EN_BIT   = 0;
  localparam int TIMER_IE_BIT   = 1;
  localparam int TIMER_PEND_BIT = 2;

  // Build the CTRL read word; every bit other than EN/IE/PEND reads 0.
  function automatic logic [31:0] ctrl_word(input logic en, input logic ie,
                                            input logic pend);
    logic [31:0] w;
    w                 = 32'h0;
    w[TIMER_EN_BIT]   = en;
    w[TIMER_IE_BIT]   = ie;
    w[TIMER_PEND_BIT] = pend;
    return w;
  endfunction

endpackage

// File: rtl/timer_slave_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the clock into timer ticks. The internal counter runs while en=1
// and wraps when it equals prescale, so a tick is produced every
// prescale+1 cycles (prescale=0 -> tick every cycle). en=0 or clr=1 returns
// the counter to 0.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   en        in   timer enable (CTRL.EN)
//   clr       in   synchronous clear (PRESCALE register being written)
//   prescale  in   PRESCALE_WIDTH-bit divide value
//   tick      out  one-cycle tick, combinational from counter and prescale
// -----------------------------------------------------------------------------
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] pcnt_q;
  logic [PRESCALE_WIDTH-1:0] pcnt_d;
  logic                      wrap;

  assign wrap = (pcnt_q == prescale);
  assign tick = en & wrap;

  always_comb begin
    pcnt_d = pcnt_q;
    if (!en || clr) begin
      pcnt_d = '0;
    end else if (wrap) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/timer_slave.sv
// -----------------------------------------------------------------------------
// timer_slave
// 32-bit memory-mapped timer on a RIB slave port. The counter advances on
// each tick while EN=1 and restarts from 0 when it reaches a non-zero VALUE,
// setting PEND. int_sig_o = PEND & IE (level, active-high).
//
// Register map (addr_i[3:0]):
//   0x0 CTRL     bit0 EN, bit1 IE, bit2 PEND (write 1 to clear)
//   0x4 COUNT    read-only
//   0x8 VALUE    R/W compare value; a write also restarts COUNT at 0
//   0xC PRESCALE R/W when TIMER_PRESCALE_EN is defined, else reads 0
//
// Optional feature macro: TIMER_PRESCALE_EN (adds the prescaler).
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   addr_i     in   bus address (only [3:0] decoded)
//   data_i     in   bus write data
//   we_i       in   write enable, write happens on this clk edge
//   data_o     out  read data, combinational from addr_i and registers
//   int_sig_o  out  timer interrupt
// -----------------------------------------------------------------------------
module timer_slave
  import timer_slave_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  logic                 en_q, en_d;
  logic                 ie_q, ie_d;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] value_q, value_d;

  logic [3:0] offs;
  logic       wr_ctrl;
  logic       wr_value;
  logic       tick;
  logic       match;

  // Upper address bits are intentionally not decoded.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:4];

  assign offs     = addr_i[3:0];
  assign wr_ctrl  = we_i && (offs == TIMER_CTRL);
  assign wr_value = we_i && (offs == TIMER_VALUE);

`ifdef TIMER_PRESCALE_EN
  logic                      wr_prescale;
  logic [PRESCALE_WIDTH-1:0] prescale_q;

  assign wr_prescale = we_i && (offs == TIMER_PRESCALE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
    end else if (wr_prescale) begin
      prescale_q <= data_i[PRESCALE_WIDTH-1:0];
    end
  end

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en_q),
    .clr     (wr_prescale),
    .prescale(prescale_q),
    .tick    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Match is evaluated with the registered EN, so a CTRL write on the same
  // edge cannot start or cancel it.
  assign match = en_q && tick && (value_q != '0) && (count_q == value_q);

  always_comb begin
    en_d    = en_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    count_d = count_q;
    value_d = value_q;

    if (en_q && tick) begin
      if (match) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;   // natural wrap at 2^CNT_WIDTH
      end
    end

    if (wr_ctrl) begin
      en_d = data_i[TIMER_EN_BIT];
      ie_d = data_i[TIMER_IE_BIT];
      if (data_i[TIMER_PEND_BIT]) begin
        pend_d = 1'b0;
      end
    end

    // A new match outranks the write-1-to-clear on the same edge.
    if (match) begin
      pend_d = 1'b1;
    end

    // Rewriting VALUE restarts the period, overriding any increment.
    if (wr_value) begin
      value_d = data_i[CNT_WIDTH-1:0];
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      count_q <= '0;
      value_q <= '0;
    end else begin
      en_q    <= en_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      value_q <= value_d;
    end
  end

  assign int_sig_o = pend_q & ie_q;

  always_comb begin
    data_o = 32'h0;
    case (offs)
      TIMER_CTRL:     data_o = ctrl_word(en_q, ie_q, pend_q);
      TIMER_COUNT:    data_o = 32'(count_q);
      TIMER_VALUE:    data_o = 32'(value_q);
`ifdef TIMER_PRESCALE_EN
      TIMER_PRESCALE: data_o = 32'(prescale_q);
`endif
      default:        data_o = 32'h0;
    endcase
  end

endmodule

// File: doc/timer_slave.md
Name: timer_slave

Overview:
- Memory-mapped 32-bit timer that acts as a responder (slave) on the core's RIB bus slave-port interface: address, write data, read data and write enable.
- Receives the bus master's accesses through one slave port (sN_addr_o / sN_data_o / sN_we_o into this block; data_o back to sN_data_i).
- Provides a periodic compare-match interrupt, intended to drive one bit of the core's int_i bus.

Parameters:
- CNT_WIDTH, 32, width of the COUNT and VALUE registers (≤ 32; read data zero-extended to 32).
- PRESCALE_WIDTH, 16, width of the PRESCALE register (used only with TIMER_PRESCALE_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- addr_i  input  32  bus address from slave port; only addr_i[3:0] decoded, upper bits ignored
- data_i  input  32  bus write data
- we_i  input  1  write enable; 1 = write on this clk edge
- data_o  output  32  read data, combinational from addr_i and the registers
- int_sig_o  output  1  timer interrupt, level, active-high

Behaviour:
- Register map (word offsets, addr_i[3:0]):
  - 0x0 CTRL: bit0 EN, bit1 IE, bit2 PEND. PEND is write-1-to-clear. All other bits read 0.
  - 0x4 COUNT: read-only; writes ignored.
  - 0x8 VALUE: R/W compare value.
  - 0xC PRESCALE: see Optional Feature.
  - Other offsets: read 0, writes ignored.
- Reset (async, immediate, also mid-count): EN=0, IE=0, PEND=0, COUNT=0, VALUE=0, PRESCALE=0, prescale counter=0; int_sig_o=0.
- Reads: data_o valid in the same cycle as addr_i (zero wait state), no side effects. we_i is ignored for reads.
- Writes take effect at the clk edge where we_i=1. There is no req/ack; every write cycle is accepted.
- tick = 1 every cycle (or per prescaler, when enabled).
- On each edge with EN=1 and tick=1:
  - if VALUE≠0 and COUNT==VALUE: COUNT←0, PEND←1;
  - else COUNT←COUNT+1, wrapping 2^CNT_WIDTH−1→0 with no flag.
- VALUE=0: the counter free-runs and never matches.
- EN=0: COUNT holds; PEND holds.
- Match period = VALUE+1 ticks.
- Write to VALUE also forces COUNT←0 on the same edge, overriding the increment.
- int_sig_o = PEND & IE, combinational from registers. It asserts in the cycle after the matching edge and stays high until PEND is cleared or IE is cleared.
- Simultaneous events:
  - CTRL write with bit2=1 on the same edge as a new match: PEND stays 1 (set wins).
  - CTRL write with bit2=0 never sets PEND.
  - CTRL write updating EN on a match edge: the match is evaluated with the old EN.
- No internal state machine beyond counters. Sequential state: CTRL, COUNT, VALUE, PRESCALE, prescale counter.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - PRESCALE register at 0x4-aligned offset 0xC (R/W, PRESCALE_WIDTH bits, zero-extended read).
  - An internal prescale counter runs while EN=1 and wraps at PRESCALE; tick=1 on the wrap cycle, so tick period = PRESCALE+1 cycles.
  - PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE, or EN=0, resets the prescale counter to 0.
- Not defined: 0xC reads 0, writes ignored, tick=1 every cycle; no prescaler logic synthesised.

Decomposition:
- defines.v (shared include) gets:
  - offsets TIMER_CTRL 4'h0, TIMER_COUNT 4'h4, TIMER_VALUE 4'h8, TIMER_PRESCALE 4'hC;
  - CTRL bit indices TIMER_EN_BIT 0, TIMER_IE_BIT 1, TIMER_PEND_BIT 2.
- One natural sub-module, timer_prescaler, instantiated only under TIMER_PRESCALE_EN:
  - inputs: clk, rst, en, clr, prescale;
  - output: tick.
- The register file and counter stay in timer_slave.

Test Plan:
- Reset/read: after rst pulse, read 0x0/0x4/0x8/0xC → all 0; int_sig_o=0. Read 0x10 → 0.
- Periodic match: write VALUE=3, then CTRL=0x3 → COUNT reads 0,1,2,3,0. PEND=1 and int_sig_o=1 one cycle after the COUNT==3 edge; repeats every 4 cycles.
- W1C and set-wins: with PEND=1, write CTRL=0x7 on a non-match edge → PEND=0, int_sig_o=0, EN/IE stay 1. Write CTRL=0x7 on a match edge → PEND remains 1.
- Masking/hold:
  - IE=0 with match → PEND=1, int_sig_o=0; then set IE → int_sig_o=1 next cycle.
  - EN=0 → COUNT frozen at current value for 10 cycles.
- VALUE rewrite and async reset: mid-count write VALUE=5 → COUNT=0 next cycle. Assert rst asynchronously mid-cycle → all registers 0 and int_sig_o=0 before the next clk edge.
- TIMER_PRESCALE_EN: PRESCALE=2, VALUE=1, EN=1 → COUNT increments every 3 cycles; PEND set after 6 cycles. Without the macro, write 0xC=5 then read → 0.
